// File: rtl/chaining_record_tracker.sv
// Tracks one in-flight vector instruction's destination-register write progress
// so later instructions can chain on elements as they become available.
module chaining_record_tracker #(
  parameter int OFFSET_WIDTH = 6,
  localparam int MASK_WIDTH  = 8 * (2 ** OFFSET_WIDTH)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    issue_valid,
  output logic                    issue_ready,
  input  logic [2:0]              issue_instIndex,
  input  logic                    issue_vd_valid,
  input  logic [4:0]              issue_vd,
  input  logic [MASK_WIDTH-1:0]   issue_initMask,
  input  logic                    write_valid,
  input  logic [4:0]              write_vd,
  input  logic [OFFSET_WIDTH-1:0] write_offset,
  input  logic [2:0]              write_instIndex,
  input  logic                    write_last,
  input  logic                    release_valid,
  input  logic [2:0]              release_instIndex,
  output logic                    recordValid,
  output logic                    record_bits_vd_valid,
  output logic [4:0]              record_bits_vd_bits,
  output logic [2:0]              record_bits_instIndex,
  output logic [MASK_WIDTH-1:0]   record_bits_elementMask,
  output logic                    record_done
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t                  r_state;
  logic                    r_vd_valid;
  logic [4:0]              r_vd;
  logic [2:0]              r_inst_index;
  logic [MASK_WIDTH-1:0]   r_mask;
  logic                    r_done;

  state_t                  w_next_state;
  logic                    w_next_vd_valid;
  logic [4:0]              w_next_vd;
  logic [2:0]              w_next_inst_index;
  logic [MASK_WIDTH-1:0]   w_next_mask;
  logic                    w_next_done;

  logic                    w_release_hit;
  logic                    w_issue_fire;
  logic [4:0]              w_dist;
  logic                    w_write_hit;
  logic [OFFSET_WIDTH+2:0] w_bit_idx;

  // The write targets one of the eight registers of the group starting at r_vd;
  // the distance wraps mod 32 so groups may straddle v31 -> v0.
  assign w_dist        = write_vd - r_vd;
  assign w_bit_idx     = {w_dist[2:0], write_offset};
  assign w_write_hit   = write_valid && (r_state == ST_ACTIVE) &&
                         (write_instIndex == r_inst_index) && (w_dist[4:3] == 2'b00);
  assign w_release_hit = release_valid && (r_state != ST_IDLE) &&
                         (release_instIndex == r_inst_index);
  assign issue_ready   = (r_state == ST_IDLE) || w_release_hit;
  assign w_issue_fire  = issue_valid && issue_ready;

  // NOTE: every next-value is defaulted to its current register first, so no path
  // through this block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_next_state      = r_state;
    w_next_vd_valid   = r_vd_valid;
    w_next_vd         = r_vd;
    w_next_inst_index = r_inst_index;
    w_next_mask       = r_mask;
    w_next_done       = r_done;
    if (w_issue_fire) begin
      w_next_state      = ST_ACTIVE;
      w_next_vd_valid   = issue_vd_valid;
      w_next_vd         = issue_vd;
      w_next_inst_index = issue_instIndex;
      w_next_mask       = issue_initMask;
      w_next_done       = 1'b0;
    end else if (w_release_hit) begin
      w_next_state = ST_IDLE;
      w_next_mask  = '0;
      w_next_done  = 1'b0;
    end else begin
      case (r_state)
        ST_ACTIVE: begin
          if (w_write_hit) begin
            w_next_mask[w_bit_idx] = 1'b1;
            if (write_last) begin
              w_next_state = ST_DONE;
              w_next_done  = 1'b1;
              w_next_mask  = '1;
            end
          end
        end
        ST_DONE:  w_next_mask = '1;
        default:  ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_vd_valid   <= 1'b0;
      r_vd         <= '0;
      r_inst_index <= '0;
      r_mask       <= '0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_vd_valid   <= w_next_vd_valid;
      r_vd         <= w_next_vd;
      r_inst_index <= w_next_inst_index;
      r_mask       <= w_next_mask;
      r_done       <= w_next_done;
    end
  end

  assign recordValid             = (r_state != ST_IDLE);
  assign record_bits_vd_valid    = r_vd_valid;
  assign record_bits_vd_bits     = r_vd;
  assign record_bits_instIndex   = r_inst_index;
  assign record_bits_elementMask = r_mask;
  assign record_done             = r_done;

endmodule

// File: tb/tb_chaining_record_tracker.sv
// Directed self-checking bench for chaining_record_tracker at default parameters.
module tb_chaining_record_tracker;

  localparam int OW = 6;
  localparam int MW = 512;

  logic          clock = 1'b0;
  logic          reset;
  logic          issue_valid;
  logic          issue_ready;
  logic [2:0]    issue_instIndex;
  logic          issue_vd_valid;
  logic [4:0]    issue_vd;
  logic [MW-1:0] issue_initMask;
  logic          write_valid;
  logic [4:0]    write_vd;
  logic [OW-1:0] write_offset;
  logic [2:0]    write_instIndex;
  logic          write_last;
  logic          release_valid;
  logic [2:0]    release_instIndex;
  logic          recordValid;
  logic          record_bits_vd_valid;
  logic [4:0]    record_bits_vd_bits;
  logic [2:0]    record_bits_instIndex;
  logic [MW-1:0] record_bits_elementMask;
  logic          record_done;

  int tests = 0;
  int fails = 0;
  logic [MW-1:0] exp_mask;

  chaining_record_tracker #(.OFFSET_WIDTH(OW)) dut (
    .clock                   (clock),
    .reset                   (reset),
    .issue_valid             (issue_valid),
    .issue_ready             (issue_ready),
    .issue_instIndex         (issue_instIndex),
    .issue_vd_valid          (issue_vd_valid),
    .issue_vd                (issue_vd),
    .issue_initMask          (issue_initMask),
    .write_valid             (write_valid),
    .write_vd                (write_vd),
    .write_offset            (write_offset),
    .write_instIndex         (write_instIndex),
    .write_last              (write_last),
    .release_valid           (release_valid),
    .release_instIndex       (release_instIndex),
    .recordValid             (recordValid),
    .record_bits_vd_valid    (record_bits_vd_valid),
    .record_bits_vd_bits     (record_bits_vd_bits),
    .record_bits_instIndex   (record_bits_instIndex),
    .record_bits_elementMask (record_bits_elementMask),
    .record_done             (record_done)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] idx, input logic [4:0] vd, input logic vdv,
                       input logic [MW-1:0] init);
    issue_valid = 1'b1; issue_instIndex = idx; issue_vd = vd;
    issue_vd_valid = vdv; issue_initMask = init;
  endtask

  task automatic write(input logic [2:0] idx, input logic [4:0] vd,
                       input logic [OW-1:0] off, input logic last);
    write_valid = 1'b1; write_instIndex = idx; write_vd = vd;
    write_offset = off; write_last = last;
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0; write_valid = 1'b0; write_last = 1'b0; release_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    issue_instIndex = '0; issue_vd = '0; issue_vd_valid = 1'b0; issue_initMask = '0;
    write_vd = '0; write_offset = '0; write_instIndex = '0; release_instIndex = '0;
    idle_inputs();
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_valid", recordValid, 0);
    check("rst_mask", record_bits_elementMask, 0);
    check("rst_done", record_done, 0);
    check("rst_idx", record_bits_instIndex, 0);
    check("rst_vd", record_bits_vd_bits, 0);
    check("rst_vdv", record_bits_vd_valid, 0);
    check("rst_ready", issue_ready, 1);

    // Basic issue and a single write hit (d=1, offset 3 -> bit 67)
    issue(3'd2, 5'd4, 1'b1, '0);
    tick(); idle_inputs(); #1;
    check("iss_valid", recordValid, 1);
    check("iss_idx", record_bits_instIndex, 2);
    check("iss_vd", record_bits_vd_bits, 4);
    check("iss_vdv", record_bits_vd_valid, 1);
    check("iss_mask", record_bits_elementMask, 0);
    check("iss_ready", issue_ready, 0);
    write(3'd2, 5'd5, 6'd3, 1'b0);
    tick(); idle_inputs(); #1;
    exp_mask = '0; exp_mask[67] = 1'b1;
    check("w67_mask", record_bits_elementMask, exp_mask);
    check("w67_valid", recordValid, 1);

    // Release in ACTIVE: mask/done clear, other fields hold
    release_valid = 1'b1; release_instIndex = 3'd2; #1;
    check("rel_ready", issue_ready, 1);
    tick(); idle_inputs(); #1;
    check("rel_valid", recordValid, 0);
    check("rel_mask", record_bits_elementMask, 0);
    check("rel_idx_hold", record_bits_instIndex, 2);
    check("rel_vd_hold", record_bits_vd_bits, 4);

    // Wrapping register group vd=30, ordering-only record (vd_valid=0)
    issue(3'd1, 5'd30, 1'b0, '0);
    tick(); idle_inputs(); #1;
    check("o_valid", recordValid, 1);
    check("o_vdv", record_bits_vd_valid, 0);
    write(3'd1, 5'd1, 6'd0, 1'b0);
    tick(); idle_inputs(); #1;
    exp_mask = '0; exp_mask[192] = 1'b1;
    check("w192_mask", record_bits_elementMask, exp_mask);
    write(3'd1, 5'd6, 6'd7, 1'b0);
    tick(); idle_inputs(); #1;
    check("d8_ignored", record_bits_elementMask, exp_mask);
    write(3'd0, 5'd1, 6'd1, 1'b0);
    tick(); idle_inputs(); #1;
    check("idx_ignored", record_bits_elementMask, exp_mask);
    write(3'd1, 5'd30, 6'd63, 1'b0);
    tick(); idle_inputs(); #1;
    exp_mask[63] = 1'b1;
    check("w63_mask", record_bits_elementMask, exp_mask);
    write(3'd1, 5'd5, 6'd63, 1'b0);
    tick(); idle_inputs(); #1;
    exp_mask[511] = 1'b1;
    check("w511_mask", record_bits_elementMask, exp_mask);
    write(3'd1, 5'd5, 6'd63, 1'b0);
    tick(); idle_inputs(); #1;
    check("reset_bit_again", record_bits_elementMask, exp_mask);
    release_valid = 1'b1; release_instIndex = 3'd5; #1;
    check("relmiss_ready", issue_ready, 0);
    tick(); idle_inputs(); #1;
    check("relmiss_valid", recordValid, 1);
    release_valid = 1'b1; release_instIndex = 3'd1;
    tick(); idle_inputs(); #1;
    check("rel2_valid", recordValid, 0);

    // Last write -> DONE with all-ones mask; later writes have no effect
    issue(3'd3, 5'd8, 1'b1, 512'hF0);
    tick(); idle_inputs(); #1;
    check("init_mask", record_bits_elementMask, 512'hF0);
    write(3'd3, 5'd8, 6'd5, 1'b1);
    tick(); idle_inputs(); #1;
    check("done_flag", record_done, 1);
    check("done_mask", record_bits_elementMask, {MW{1'b1}});
    check("done_valid", recordValid, 1);
    check("done_ready", issue_ready, 0);
    write(3'd3, 5'd9, 6'd0, 1'b0);
    tick(); idle_inputs(); #1;
    check("done_w_flag", record_done, 1);
    check("done_w_mask", record_bits_elementMask, {MW{1'b1}});

    // Same-cycle release and issue: issue wins
    release_valid = 1'b1; release_instIndex = 3'd3;
    issue(3'd4, 5'd2, 1'b1, 512'h1); #1;
    check("ri_ready", issue_ready, 1);
    tick(); idle_inputs(); #1;
    check("ri_valid", recordValid, 1);
    check("ri_idx", record_bits_instIndex, 4);
    check("ri_vd", record_bits_vd_bits, 2);
    check("ri_mask", record_bits_elementMask, 512'h1);
    check("ri_done", record_done, 0);

    // Issue while busy without release is not accepted
    issue(3'd6, 5'd10, 1'b1, '0);
    tick(); idle_inputs(); #1;
    check("busy_idx", record_bits_instIndex, 4);
    check("busy_mask", record_bits_elementMask, 512'h1);

    // Reset mid-instruction overrides a concurrent issue
    write(3'd4, 5'd2, 6'd9, 1'b0);
    tick(); idle_inputs(); #1;
    check("w9_mask", record_bits_elementMask, 512'h201);
    reset = 1'b1;
    issue(3'd5, 5'd7, 1'b1, 512'hFF);
    tick(); reset = 1'b0; idle_inputs(); #1;
    check("mrst_valid", recordValid, 0);
    check("mrst_mask", record_bits_elementMask, 0);
    check("mrst_idx", record_bits_instIndex, 0);
    check("mrst_ready", issue_ready, 1);

    // Release while IDLE (index matches held 0) changes nothing
    release_valid = 1'b1; release_instIndex = 3'd0;
    tick(); idle_inputs(); #1;
    check("idlerel_valid", recordValid, 0);
    check("idlerel_mask", record_bits_elementMask, 0);
    check("idlerel_ready", issue_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
